// File: rtl/multicycle_control_if.sv
// Control/status bundle between the multi-cycle sequencer and the LEGv8 datapath.
// Handshake: the sequencer holds mem_read or mem_write high and constant until
// the first rising edge on which mem_ready is also high; that edge completes
// the access. mem_ready outside FETCH/MEM_RD/MEM_WR is ignored.
interface multicycle_control_if #(
  parameter int RETIRE_W = 32
);
  logic [10:0]         inst31_21;
  logic                zero;
  logic                mem_ready;
  logic                pc_write;
  logic                pc_src;
  logic                ir_write;
  logic                mem_read;
  logic                mem_write;
  logic                i_or_d;
  logic                reg2loc;
  logic [1:0]          alu_src_b;
  logic [1:0]          ALUOp;
  logic                reg_write;
  logic                mem_to_reg;
  logic                trap;
  logic [3:0]          state;
  logic [RETIRE_W-1:0] retired;

  // Sequencer side: drives every control output, reads opcode/flags/ready.
  modport master (
    input  inst31_21, zero, mem_ready,
    output pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg2loc,
           alu_src_b, ALUOp, reg_write, mem_to_reg, trap, state, retired
  );

  // Datapath/memory side: supplies opcode/flags/ready, consumes controls.
  modport slave (
    output inst31_21, zero, mem_ready,
    input  pc_write, pc_src, ir_write, mem_read, mem_write, i_or_d, reg2loc,
           alu_src_b, ALUOp, reg_write, mem_to_reg, trap, state, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle LEGv8 core. Moore-style FSM stepping each
// instruction through fetch/decode/execute/memory/write-back; outputs decode
// from the registered state, with the FETCH load strobes gated by mem_ready
// and the BRANCH PC load gated by zero. Counts retired instructions.
module multicycle_control #(
  parameter int RETIRE_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EXEC_R   = 4'd3,
    EXEC_I   = 4'd4,
    MEM_ADDR = 4'd5,
    MEM_RD   = 4'd6,
    MEM_WR   = 4'd7,
    WB_R     = 4'd8,
    WB_MEM   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11,
    TRAP     = 4'd12
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  state_t              state_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                trap_q;
  logic                is_stur;
  logic                is_cbz;

  assign is_stur = (bus.inst31_21 == OP_STUR);
  assign is_cbz  = (bus.inst31_21[10:3] == 8'b10110100);

  // Opcode classification; earlier matches take priority.
  function automatic state_t classify(input logic [10:0] op);
    if (op == OP_ADD || op == OP_SUB || op == OP_AND || op == OP_ORR)
      classify = EXEC_R;
    else if (op[10:1] == 10'b1001000100)
      classify = EXEC_I;
    else if (op == OP_LDUR || op == OP_STUR)
      classify = MEM_ADDR;
    else if (op[10:3] == 8'b10110100)
      classify = BRANCH;
    else if (op[10:5] == 6'b000101)
      classify = JUMP;
    else
      classify = TRAP;
  endfunction

  // State sequencing, sticky trap flag and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      retired_q <= '0;
      trap_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE:     state_q <= FETCH;
        FETCH:    if (bus.mem_ready) state_q <= DECODE;
        DECODE: begin
          state_q <= classify(bus.inst31_21);
          if (classify(bus.inst31_21) == TRAP) trap_q <= 1'b1;
        end
        EXEC_R:   state_q <= WB_R;
        EXEC_I:   state_q <= WB_R;
        MEM_ADDR: state_q <= is_stur ? MEM_WR : MEM_RD;
        MEM_RD:   if (bus.mem_ready) state_q <= WB_MEM;
        MEM_WR: begin
          if (bus.mem_ready) begin
            state_q   <= FETCH;
            retired_q <= retired_q + RETIRE_W'(1);
          end
        end
        WB_R, WB_MEM, BRANCH, JUMP: begin
          state_q   <= FETCH;
          retired_q <= retired_q + RETIRE_W'(1);
        end
        TRAP:     state_q <= TRAP;
        default:  state_q <= IDLE;
      endcase
    end
  end

  // Datapath controls decoded from the current state.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.pc_src     = 1'b0;
    bus.ir_write   = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.reg2loc    = 1'b0;
    bus.alu_src_b  = 2'b00;
    bus.ALUOp      = 2'b00;
    bus.reg_write  = 1'b0;
    bus.mem_to_reg = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_read  = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
      end
      DECODE:   bus.reg2loc = is_stur | is_cbz;
      EXEC_R:   bus.ALUOp = 2'b10;
      EXEC_I:   bus.alu_src_b = 2'b10;
      MEM_ADDR: begin
        bus.alu_src_b = 2'b10;
        bus.reg2loc   = is_stur;
      end
      MEM_RD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
      end
      MEM_WR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        bus.reg2loc   = 1'b1;
      end
      WB_R:     bus.reg_write = 1'b1;
      WB_MEM: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
      end
      BRANCH: begin
        bus.reg2loc  = 1'b1;
        bus.ALUOp    = 2'b01;
        bus.pc_src   = 1'b1;
        bus.pc_write = bus.zero;
      end
      JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.trap    = trap_q;
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main sequencer for the multi-cycle LEGv8 core: a Moore FSM that steps each instruction through fetch, decode, execute, memory and write-back. It drives the shared datapath enables and the 2-bit `ALUOp` consumed by the ALU control decoder. It sits between instruction/data memory and the register file/ALU. It also stalls on a single memory ready handshake and counts retired instructions.

## Interface
- `RETIRE_W`, 32: width of retired-instruction counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `inst31_21`  in  11  opcode field of the instruction register (valid from DECODE on).
- `zero`  in  1  ALU zero flag (CBZ test).
- `mem_ready`  in  1  memory completes current read/write this cycle.
- `pc_write`  out  1  load PC this cycle.
- `pc_src`  out  1  0 = PC+4, 1 = branch/jump target.
- `ir_write`  out  1  load instruction register.
- `mem_read`  out  1  memory read request (instruction or data).
- `mem_write`  out  1  memory write request.
- `i_or_d`  out  1  0 = address from PC, 1 = address from ALU out.
- `reg2loc`  out  1  1 = read register 2 from Rt (STUR/CBZ).
- `alu_src_b`  out  2  00 = reg B, 01 = const 4, 10 = sign-ext immediate.
- `ALUOp`  out  2  00 = add, 01 = pass B (CBZ), 10 = R-type decode.
- `reg_write`  out  1  register file write.
- `mem_to_reg`  out  1  1 = write-back from memory data register.
- `trap`  out  1  illegal opcode seen; sticky until reset.
- `state`  out  4  current state code (debug).
- `retired`  out  RETIRE_W  instructions completed, wraps modulo 2^RETIRE_W.

## Operation
- State codes: IDLE 0, FETCH 1, DECODE 2, EXEC_R 3, EXEC_I 4, MEM_ADDR 5, MEM_RD 6, MEM_WR 7, WB_R 8, WB_MEM 9, BRANCH 10, JUMP 11, TRAP 12.
- IDLE → FETCH unconditionally. All outputs are 0 in IDLE.
- FETCH: `mem_read`=1, `i_or_d`=0, `alu_src_b`=01, `ALUOp`=00. If `mem_ready`: `ir_write`=1, `pc_write`=1, `pc_src`=0, go DECODE; otherwise stay in FETCH with `ir_write`/`pc_write` 0.
- DECODE classifies `inst31_21`, first match wins:
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 → EXEC_R.
  - ADDI [10:1]=1001000100 → EXEC_I.
  - LDUR 11111000010 / STUR 11111000000 → MEM_ADDR.
  - CBZ [10:3]=10110100 → BRANCH.
  - B [10:5]=000101 → JUMP.
  - anything else → TRAP.
- DECODE asserts `reg2loc`=1 for STUR/CBZ.
- EXEC_R: `alu_src_b`=00, `ALUOp`=10 → WB_R.
- EXEC_I: `alu_src_b`=10, `ALUOp`=00 → WB_R.
- MEM_ADDR: `alu_src_b`=10, `ALUOp`=00, `reg2loc`=1 if STUR → MEM_RD (LDUR) or MEM_WR (STUR). Opcode is re-read from `inst31_21`; the IR is stable.
- MEM_RD: `mem_read`=1, `i_or_d`=1; on `mem_ready` → WB_MEM, else hold.
- MEM_WR: `mem_write`=1, `i_or_d`=1, `reg2loc`=1; on `mem_ready` → FETCH (retire), else hold.
- WB_R: `reg_write`=1, `mem_to_reg`=0 → FETCH (retire).
- WB_MEM: `reg_write`=1, `mem_to_reg`=1 → FETCH (retire).
- BRANCH: `reg2loc`=1, `alu_src_b`=00, `ALUOp`=01, `pc_src`=1, `pc_write`=`zero` → FETCH (retire, taken or not).
- JUMP: `pc_write`=1, `pc_src`=1 → FETCH (retire).
- TRAP: all datapath outputs 0, `trap`=1, no exit except reset; `retired` frozen.
- Retire: `retired` increments by 1 on the clock edge leaving a retiring state.

## Timing
- Reset: on the first edge with `reset`=1, state=IDLE, `retired`=0, `trap`=0. All outputs are 0 while in IDLE. This applies in any state, including mid-memory-wait: a pending `mem_ready` is ignored and no write-back occurs.
- With `mem_ready` tied 1, cycles per instruction: R-type/ADDI 4, LDUR 5, STUR 4, CBZ 3, B 3. Each cycle `mem_ready` is low in FETCH/MEM_RD/MEM_WR adds exactly one cycle.
- Request outputs `mem_read`/`mem_write` stay high and constant for the whole wait. The handshake completes on the first edge where the request and `mem_ready` are both high.
- `mem_ready` in any state other than FETCH/MEM_RD/MEM_WR is ignored.
- `zero` is sampled only in BRANCH.
- `inst31_21` is sampled in DECODE and MEM_ADDR.
- Counter wrap: all-ones + retire → 0, with no flag.

## Test plan
- Reset then `mem_ready`=1, IR=ADD 10001011000 → states 0,1,2,3,8,1. `ALUOp`=10 in EXEC_R, `reg_write`=1 in WB_R, `retired`=1.
- LDUR with `mem_ready` low for 2 cycles in MEM_RD → MEM_RD held 3 cycles with `mem_read`=1, `i_or_d`=1. WB_MEM then shows `mem_to_reg`=1. Total 7 cycles.
- CBZ with `zero`=1, then with `zero`=0 → BRANCH shows `ALUOp`=01, `pc_src`=1, and `pc_write`=1 then 0. Both retire; `retired`=2.
- Opcode 00000000000 → TRAP after DECODE. `trap`=1 and all enables 0 for 20 cycles, `retired` unchanged. `reset` → IDLE, `trap`=0.
- Assert `reset` in MEM_WR while `mem_ready`=1 → next state IDLE. `mem_write` is 0 after the edge and `retired` is 0.
- `RETIRE_W`=4, run 16 B instructions → `retired` wraps 15 → 0.
